vga_frame_renderer: RTL and testbench

Pixel-side counterpart of the game core: generates 640×480@60 Hz VGA timing, presents each pixel coordinate to the game logic, accepts the returned 2-bit entity code one cycle later and turns it into RGB, with hsync/vsync/blanking pipelined to match. It also produces the frame-rate game update tick. It sits between the board's 25 MHz pixel clock and the VGA DAC pins.

---
 rtl/vga_frame_renderer_pkg.sv | 32 +++
 rtl/vga_sync_counter.sv | 60 ++++++
 rtl/vga_frame_renderer.sv | 141 ++++++++++++++
 tb/tb_vga_frame_renderer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_frame_renderer_pkg.sv
// Shared definitions for the VGA frame renderer: entity codes, palette
// and the default 640x480@60 Hz timing numbers.
package vga_frame_renderer_pkg;

    // Entity code returned by the game logic for each presented coordinate
    typedef enum logic [1:0] {
        ENT_NOTHING    = 2'd0,
        ENT_SNAKE_HEAD = 2'd1,
        ENT_SNAKE_TAIL = 2'd2,
        ENT_APPLE      = 2'd3
    } entity_e;

    // Palette, {R[3:0],G[3:0],B[3:0]}
    localparam logic [11:0] COLOR_BG      = 12'h000;
    localparam logic [11:0] COLOR_HEAD    = 12'h0F0;
    localparam logic [11:0] COLOR_TAIL    = 12'h080;
    localparam logic [11:0] COLOR_APPLE   = 12'hF00;
    localparam logic [11:0] COLOR_OVER_BG = 12'h400;
    localparam logic [11:0] COLOR_WON_BG  = 12'h040;

    // Default 640x480@60 Hz timing (25 MHz pixel clock)
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_UPDATE_DIV = 8;

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical raster counters with the raw (stage 0) display
// enable, active-low sync levels and an end-of-frame strobe.
module vga_sync_counter
    import vga_frame_renderer_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] o_h_cnt,
    output logic [9:0] o_v_cnt,
    output logic       o_de,
    output logic       o_hs_n,
    output logic       o_vs_n,
    output logic       o_frame_end
);

    localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_LO = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_HI = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST    = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_LO = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_HI = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST    = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       w_line_end;

    assign w_line_end = (r_h_cnt == H_LAST);

    // Raster scan: h wraps every line, v advances on each line wrap
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
        end else if (w_line_end) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    assign o_h_cnt     = r_h_cnt;
    assign o_v_cnt     = r_v_cnt;
    assign o_de        = (r_h_cnt < H_VIS_END) && (r_v_cnt < V_VIS_END);
    assign o_hs_n      = !((r_h_cnt >= H_SYNC_LO) && (r_h_cnt < H_SYNC_HI));
    assign o_vs_n      = !((r_v_cnt >= V_SYNC_LO) && (r_v_cnt < V_SYNC_HI));
    assign o_frame_end = w_line_end && (r_v_cnt == V_LAST);

endmodule

// File: rtl/vga_frame_renderer.sv
// VGA frame renderer: presents raster coordinates to the game logic,
// turns the returned entity code into RGB two cycles later with syncs
// delayed to match, and divides frames down into the game update tick.
module vga_frame_renderer
    import vga_frame_renderer_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int UPDATE_DIV = DEF_UPDATE_DIV
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic [9:0]  x_out,
    output logic [9:0]  y_out,
    input  logic [1:0]  entity,
    input  logic        game_over,
    input  logic        game_won,
    output logic        update_tick,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb
);

    localparam int            FW         = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(UPDATE_DIV - 1);

    logic          w_de;
    logic          w_hs_n;
    logic          w_vs_n;
    logic          w_frame_end;
    entity_e       w_entity;
    logic [11:0]   w_pixel_rgb;

    logic          r_de_d1;
    logic          r_hs_n_d1;
    logic          r_vs_n_d1;
    logic [11:0]   r_rgb;
    logic          r_hsync;
    logic          r_vsync;
    logic [FW-1:0] r_frame_cnt;
    logic          r_update_tick;

    vga_sync_counter #(
        .H_VISIBLE (H_VISIBLE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_VISIBLE (V_VISIBLE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP)
    ) u_sync (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .o_h_cnt     (x_out),
        .o_v_cnt     (y_out),
        .o_de        (w_de),
        .o_hs_n      (w_hs_n),
        .o_vs_n      (w_vs_n),
        .o_frame_end (w_frame_end)
    );

    assign w_entity = entity_e'(entity);

    // Stage 1: hold raster qualifiers while the game logic registers entity
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_de_d1   <= 1'b0;
            r_hs_n_d1 <= 1'b1;
            r_vs_n_d1 <= 1'b1;
        end else begin
            r_de_d1   <= w_de;
            r_hs_n_d1 <= w_hs_n;
            r_vs_n_d1 <= w_vs_n;
        end
    end

    // Map entity code to colour; blank area and empty cells get background
    always_comb begin
        w_pixel_rgb = COLOR_BG;
        if (r_de_d1) begin
            case (w_entity)
                ENT_SNAKE_HEAD: w_pixel_rgb = COLOR_HEAD;
                ENT_SNAKE_TAIL: w_pixel_rgb = COLOR_TAIL;
                ENT_APPLE:      w_pixel_rgb = COLOR_APPLE;
                default: begin
                    if (game_won) begin
                        w_pixel_rgb = COLOR_WON_BG;
                    end else if (game_over) begin
                        w_pixel_rgb = COLOR_OVER_BG;
                    end else begin
                        w_pixel_rgb = COLOR_BG;
                    end
                end
            endcase
        end
    end

    // Stage 2: register pixel colour and syncs so they leave together
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_rgb   <= 12'h000;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_rgb   <= w_pixel_rgb;
            r_hsync <= r_hs_n_d1;
            r_vsync <= r_vs_n_d1;
        end
    end

    // Count frames; pulse the update tick for one cycle every UPDATE_DIV frames
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_frame_cnt   <= '0;
            r_update_tick <= 1'b0;
        end else begin
            r_update_tick <= 1'b0;
            if (w_frame_end) begin
                if (r_frame_cnt == FRAME_LAST) begin
                    r_frame_cnt   <= '0;
                    r_update_tick <= 1'b1;
                end else begin
                    r_frame_cnt <= r_frame_cnt + FW'(1);
                end
            end
        end
    end

    assign rgb         = r_rgb;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign update_tick = r_update_tick;

endmodule

// File: tb/tb_vga_frame_renderer.sv
// Testbench for vga_frame_renderer on a shrunken raster so whole frames
// and several update ticks fit in a short run.
module tb_vga_frame_renderer;
    import vga_frame_renderer_pkg::*;

    localparam int HV  = 40;
    localparam int HFP = 4;
    localparam int HS  = 8;
    localparam int HBP = 4;
    localparam int VV  = 20;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int DIV = 2;
    localparam int HT  = HV + HFP + HS + HBP;
    localparam int VT  = VV + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    logic        vga_clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  x_out;
    logic [9:0]  y_out;
    logic [1:0]  entity = ENT_NOTHING;
    logic        game_over = 1'b0;
    logic        game_won = 1'b0;
    logic        update_tick;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;

    int checks = 0;
    int failures = 0;
    int k = 0;
    logic [1:0] ent_prev = ENT_NOTHING;
    logic       won_prev = 1'b0;
    logic       over_prev = 1'b0;

    vga_frame_renderer #(
        .H_VISIBLE (HV), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_VISIBLE (VV), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .UPDATE_DIV (DIV)
    ) dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .x_out       (x_out),
        .y_out       (y_out),
        .entity      (entity),
        .game_over   (game_over),
        .game_won    (game_won),
        .update_tick (update_tick),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb)
    );

    always #5 vga_clk = ~vga_clk;

    // Reference model: cycle k counts from the first cycle after reset
    // release; the raster position in that cycle is index k, and the
    // outputs in cycle k describe raster index k-2.
    function automatic int coord_h(input int j);
        return j % HT;
    endfunction

    function automatic int coord_v(input int j);
        return (j / HT) % VT;
    endfunction

    function automatic logic exp_hsync(input int kk);
        int h;
        if (kk < 2) return 1'b1;
        h = coord_h(kk - 2);
        return !(h >= HV + HFP && h < HV + HFP + HS);
    endfunction

    function automatic logic exp_vsync(input int kk);
        int v;
        if (kk < 2) return 1'b1;
        v = coord_v(kk - 2);
        return !(v >= VV + VFP && v < VV + VFP + VS);
    endfunction

    function automatic logic exp_visible(input int kk);
        if (kk < 2) return 1'b0;
        return (coord_h(kk - 2) < HV) && (coord_v(kk - 2) < VV);
    endfunction

    function automatic logic [11:0] exp_colour(input int kk, input logic [1:0] ent,
                                               input logic won, input logic over);
        if (!exp_visible(kk)) return 12'h000;
        case (ent)
            ENT_SNAKE_HEAD: return 12'h0F0;
            ENT_SNAKE_TAIL: return 12'h080;
            ENT_APPLE:      return 12'hF00;
            default:        return won ? 12'h040 : (over ? 12'h400 : 12'h000);
        endcase
    endfunction

    function automatic logic exp_tick(input int kk);
        return (kk > 0) && (kk % (DIV * FRAME) == 0);
    endfunction

    // Advance one clock, remembering what the inputs were during the cycle just ended
    task automatic tick_clk();
        ent_prev  = entity;
        won_prev  = game_won;
        over_prev = game_over;
        @(posedge vga_clk);
        #1;
        k++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick_clk();
        reset = 1'b0;
        k = 0;
    endtask

    task automatic test_reset();
        entity = ENT_NOTHING;
        do_reset();
        checks++; if (x_out !== 10'd0) begin failures++; $display("FAIL reset_x got=%0d exp=0", x_out); end
        checks++; if (y_out !== 10'd0) begin failures++; $display("FAIL reset_y got=%0d exp=0", y_out); end
        checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL reset_rgb got=%h exp=000", rgb); end
        checks++; if (hsync !== 1'b1) begin failures++; $display("FAIL reset_hsync got=%b exp=1", hsync); end
        checks++; if (vsync !== 1'b1) begin failures++; $display("FAIL reset_vsync got=%b exp=1", vsync); end
        checks++; if (update_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", update_tick); end
    endtask

    task automatic test_blank_timing();
        int hs_low = 0;
        int vs_low = 0;
        entity = ENT_NOTHING;
        do_reset();
        for (int n = 0; n < 2 * FRAME + 12; n++) begin
            checks++; if (x_out !== 10'(coord_h(k))) begin failures++; $display("FAIL blank_x k=%0d got=%0d exp=%0d", k, x_out, coord_h(k)); end
            checks++; if (y_out !== 10'(coord_v(k))) begin failures++; $display("FAIL blank_y k=%0d got=%0d exp=%0d", k, y_out, coord_v(k)); end
            checks++; if (hsync !== exp_hsync(k)) begin failures++; $display("FAIL blank_hsync k=%0d got=%b exp=%b", k, hsync, exp_hsync(k)); end
            checks++; if (vsync !== exp_vsync(k)) begin failures++; $display("FAIL blank_vsync k=%0d got=%b exp=%b", k, vsync, exp_vsync(k)); end
            checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL blank_rgb k=%0d got=%h exp=000", k, rgb); end
            checks++; if (update_tick !== exp_tick(k)) begin failures++; $display("FAIL blank_tick k=%0d got=%b exp=%b", k, update_tick, exp_tick(k)); end
            if (k >= 2 && k < 2 + 2 * FRAME) begin
                if (hsync === 1'b0) hs_low++;
                if (vsync === 1'b0) vs_low++;
            end
            tick_clk();
        end
        checks++; if (hs_low != 2 * VT * HS) begin failures++; $display("FAIL hsync_low_total got=%0d exp=%0d", hs_low, 2 * VT * HS); end
        checks++; if (vs_low != 2 * VS * HT) begin failures++; $display("FAIL vsync_low_total got=%0d exp=%0d", vs_low, 2 * VS * HT); end
    endtask

    task automatic test_apple();
        for (int run = 0; run < 2; run++) begin
            int ax = int'($urandom_range(0, HV - 1));
            int ay = int'($urandom_range(0, VV - 1));
            int hits = 0;
            logic [11:0] exp_c;
            logic [9:0] cx;
            logic [9:0] cy;
            entity = ENT_NOTHING;
            do_reset();
            for (int n = 0; n < FRAME + 4; n++) begin
                exp_c = (k >= 2 && coord_h(k - 2) == ax && coord_v(k - 2) == ay) ? 12'hF00 : 12'h000;
                checks++; if (rgb !== exp_c) begin failures++; $display("FAIL apple_rgb k=%0d at=(%0d,%0d) got=%h exp=%h", k, ax, ay, rgb, exp_c); end
                if (rgb === 12'hF00) hits++;
                cx = x_out;
                cy = y_out;
                tick_clk();
                entity = (cx == 10'(ax) && cy == 10'(ay)) ? ENT_APPLE : ENT_NOTHING;
            end
            checks++; if (hits != 1) begin failures++; $display("FAIL apple_hits got=%0d exp=1", hits); end
        end
        entity = ENT_NOTHING;
    endtask

    task automatic test_head_constant();
        int lit = 0;
        logic [11:0] exp_c;
        entity = ENT_SNAKE_HEAD;
        do_reset();
        for (int n = 0; n < FRAME + 4; n++) begin
            exp_c = exp_visible(k) ? 12'h0F0 : 12'h000;
            checks++; if (rgb !== exp_c) begin failures++; $display("FAIL head_rgb k=%0d got=%h exp=%h", k, rgb, exp_c); end
            if (k >= 2 && k < 2 + FRAME && rgb === 12'h0F0) lit++;
            tick_clk();
        end
        checks++; if (lit != HV * VV) begin failures++; $display("FAIL head_lit_total got=%0d exp=%0d", lit, HV * VV); end
        entity = ENT_NOTHING;
    endtask

    task automatic test_update_tick();
        int pulses = 0;
        int first = -1;
        do_reset();
        for (int n = 0; n < 2 * DIV * FRAME + 5; n++) begin
            checks++; if (update_tick !== exp_tick(k)) begin failures++; $display("FAIL tick k=%0d got=%b exp=%b", k, update_tick, exp_tick(k)); end
            if (update_tick === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
            tick_clk();
        end
        checks++; if (pulses != 2) begin failures++; $display("FAIL tick_count got=%0d exp=2", pulses); end
        checks++; if (first != DIV * FRAME) begin failures++; $display("FAIL tick_first got=%0d exp=%0d", first, DIV * FRAME); end
    endtask

    task automatic test_backgrounds();
        logic [11:0] exp_c;
        entity = ENT_NOTHING;
        game_over = 1'b1;
        game_won = 1'b0;
        do_reset();
        for (int n = 0; n < 2 * FRAME; n++) begin
            if (n == FRAME) game_won = 1'b1;
            exp_c = exp_colour(k, ent_prev, won_prev, over_prev);
            checks++; if (rgb !== exp_c) begin failures++; $display("FAIL bg_rgb k=%0d over=%b won=%b got=%h exp=%h", k, over_prev, won_prev, rgb, exp_c); end
            tick_clk();
        end
        game_over = 1'b0;
        game_won = 1'b0;
    endtask

    task automatic test_random_entity();
        logic [11:0] exp_c;
        do_reset();
        for (int n = 0; n < FRAME + 10; n++) begin
            exp_c = exp_colour(k, ent_prev, won_prev, over_prev);
            checks++; if (rgb !== exp_c) begin failures++; $display("FAIL rand_rgb k=%0d ent=%0d got=%h exp=%h", k, ent_prev, rgb, exp_c); end
            checks++; if (hsync !== exp_hsync(k)) begin failures++; $display("FAIL rand_hsync k=%0d got=%b exp=%b", k, hsync, exp_hsync(k)); end
            entity = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) game_over = ~game_over;
            if ($urandom_range(0, 63) == 0) game_won = ~game_won;
            tick_clk();
        end
        entity = ENT_NOTHING;
        game_over = 1'b0;
        game_won = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [11:0] exp_c;
        entity = ENT_SNAKE_HEAD;
        do_reset();
        while (k < 10 * HT + 30) tick_clk();
        checks++; if (rgb !== 12'h0F0) begin failures++; $display("FAIL midrst_pre_rgb got=%h exp=0f0", rgb); end
        reset = 1'b1;
        tick_clk();
        reset = 1'b0;
        k = 0;
        checks++; if (x_out !== 10'd0) begin failures++; $display("FAIL midrst_x got=%0d exp=0", x_out); end
        checks++; if (y_out !== 10'd0) begin failures++; $display("FAIL midrst_y got=%0d exp=0", y_out); end
        checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL midrst_rgb got=%h exp=000", rgb); end
        checks++; if (hsync !== 1'b1) begin failures++; $display("FAIL midrst_hsync got=%b exp=1", hsync); end
        checks++; if (vsync !== 1'b1) begin failures++; $display("FAIL midrst_vsync got=%b exp=1", vsync); end
        checks++; if (update_tick !== 1'b0) begin failures++; $display("FAIL midrst_tick got=%b exp=0", update_tick); end
        for (int n = 0; n < 2 * HT + 4; n++) begin
            exp_c = exp_visible(k) ? 12'h0F0 : 12'h000;
            checks++; if (rgb !== exp_c) begin failures++; $display("FAIL midrst_run_rgb k=%0d got=%h exp=%h", k, rgb, exp_c); end
            checks++; if (x_out !== 10'(coord_h(k))) begin failures++; $display("FAIL midrst_run_x k=%0d got=%0d exp=%0d", k, x_out, coord_h(k)); end
            checks++; if (y_out !== 10'(coord_v(k))) begin failures++; $display("FAIL midrst_run_y k=%0d got=%0d exp=%0d", k, y_out, coord_v(k)); end
            checks++; if (hsync !== exp_hsync(k)) begin failures++; $display("FAIL midrst_run_hsync k=%0d got=%b exp=%b", k, hsync, exp_hsync(k)); end
            tick_clk();
        end
        entity = ENT_NOTHING;
    endtask

    initial begin
        test_reset();
        test_blank_timing();
        test_apple();
        test_head_constant();
        test_update_tick();
        test_backgrounds();
        test_random_entity();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
